// File: rtl/vedic_seq_mult.sv
// Multi-cycle unsigned WIDTH x WIDTH multiplier built around one 2x2 vedic core.
// Each CALC cycle multiplies one digit pair and shift-accumulates it into a double-width sum.

module vedic_2bits (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] q
);
    logic cross_lo;
    logic cross_hi;
    logic carry1;
    logic top;

    assign cross_lo = a[1] & b[0];
    assign cross_hi = a[0] & b[1];
    assign carry1   = cross_lo & cross_hi;
    assign top      = a[1] & b[1];

    assign q[0] = a[0] & b[0];
    assign q[1] = cross_lo ^ cross_hi;
    assign q[2] = top ^ carry1;
    assign q[3] = top & carry1;
endmodule

module vedic_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
        $error("vedic_seq_mult: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]  acc;
    logic [PW-1:0]  acc_sum;
    logic [PW-1:0]  q_ext;
    logic [IW-1:0]  i;
    logic [IW-1:0]  j;
    logic [IW:0]    digit_sum;
    logic [3:0]     q_core;
    logic           last_i;
    logic           last_j;

    assign last_i = (i == IW'(N - 1));
    assign last_j = (j == IW'(N - 1));

    vedic_2bits u_core (
        .a (a_r[2*i +: 2]),
        .b (b_r[2*j +: 2]),
        .q (q_core)
    );

    // Partial product weight is 4^(i+j), i.e. a left shift by 2*(i+j).
    always_comb begin
        q_ext        = '0;
        q_ext[3:0]   = q_core;
        digit_sum    = {1'b0, i} + {1'b0, j};
        acc_sum      = acc + (q_ext << {digit_sum, 1'b0});
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_i && last_j) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            i   <= '0;
            j   <= '0;
            P   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= A;
                        b_r <= B;
                        acc <= '0;
                        i   <= '0;
                        j   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_sum;
                    if (last_j) begin
                        j <= '0;
                        i <= last_i ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                    if (last_i && last_j) P <= acc_sum;
                end
                default: ;
            endcase
        end
    end
endmodule
